fifo_tx_scheduler: RTL and testbench

FIFO_TX_SCHEDULER -- requirements
Module: fifo_tx_scheduler

---
 rtl/fifo_tx_scheduler.sv | 93 +++++++++
 tb/tb_fifo_tx_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_scheduler.sv
// Pops words from a first-word-fall-through FIFO and hands them to a transmitter
// in bursts of up to BURST_MAX words, with a forced gap and a per-word watchdog.
module fifo_tx_scheduler #(
   parameter int NB_WORD        = 8,
   parameter int BURST_MAX      = 4,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_fifo_empty,
   input  logic [NB_WORD-1:0] i_fifo_data,
   output logic               o_fifo_read,
   output logic [NB_WORD-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_busy,
   output logic               o_timeout,
   output logic [15:0]        o_sent_count
);

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, POP, START, BUSY, GAP} state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   burst_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [WW-1:0]   wd_cnt;
   logic            done_acc;
   logic            wd_exp;
   logic            burst_more;
   logic            gap_last;

   // A done strobe on the expiry cycle takes precedence over the watchdog.
   assign done_acc   = (state == BUSY) && i_tx_done;
   assign wd_exp     = (state == BUSY) && !i_tx_done && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign burst_more = (32'(burst_cnt) + 32'd1) < 32'(BURST_MAX);
   assign gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));

   assign o_fifo_read = (state == POP);
   assign o_tx_start  = (state == START);
   assign o_busy      = (state != IDLE);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (i_enable && !i_fifo_empty) state_nxt = POP;
         POP:   state_nxt = START;
         START: state_nxt = BUSY;
         BUSY: begin
            if (done_acc)
               state_nxt = (burst_more && !i_fifo_empty && i_enable) ? POP : GAP;
            else if (wd_exp)
               state_nxt = GAP;
         end
         GAP:   if (gap_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog and gap counters sit at zero outside their state, so they never wrap.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_tx_data    <= '0;
         o_sent_count <= '0;
         o_timeout    <= 1'b0;
         burst_cnt    <= '0;
         gap_cnt      <= '0;
         wd_cnt       <= '0;
      end else begin
         o_timeout <= wd_exp;
         if (state == POP) o_tx_data <= i_fifo_data;
         if (done_acc) begin
            o_sent_count <= o_sent_count + 16'd1;
            burst_cnt    <= burst_cnt + 1'b1;
         end else if (state == GAP) begin
            burst_cnt <= '0;
         end
         wd_cnt  <= (state == BUSY && state_nxt == BUSY) ? wd_cnt + 1'b1 : '0;
         gap_cnt <= (state == GAP && state_nxt == GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Bench for fifo_tx_scheduler: FIFO and transmitter models, a transaction-level
// scoreboard, hand-timed sequences, a vector table and a randomized phase.
module tb_fifo_tx_scheduler;

   localparam int NB_WORD = 8;
   localparam int BURST_MAX = 4;
   localparam int GAP_CYCLES = 2;
   localparam int TIMEOUT_CYCLES = 8;

   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               i_enable = 1'b0;
   logic               i_fifo_empty = 1'b1;
   logic [NB_WORD-1:0] i_fifo_data = '0;
   logic               i_tx_done = 1'b0;
   logic               o_fifo_read, o_tx_start, o_busy, o_timeout;
   logic [NB_WORD-1:0] o_tx_data;
   logic [15:0]        o_sent_count;

   always #5 i_clk = ~i_clk;

   fifo_tx_scheduler #(
      .NB_WORD(NB_WORD), .BURST_MAX(BURST_MAX),
      .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
      .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
      .o_fifo_read(o_fifo_read), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
      .i_tx_done(i_tx_done), .o_busy(o_busy), .o_timeout(o_timeout),
      .o_sent_count(o_sent_count)
   );

   typedef struct {
      bit en;
      int nwords;
      int lat;        // done latency after start, 0 = never returned
      int exp_reads;
      int exp_sent;
      int exp_to;
   } vec_t;

   vec_t vecs[7];
   logic [NB_WORD-1:0] fq[$];
   logic [NB_WORD-1:0] exp_q[$];
   int st_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, cd = 0, done_lat = 1;
   bit rand_lat = 0;
   int n_reads = 0, n_starts = 0, n_to = 0, exp_sent = 0, exp_to = 0, burst_run = 0;
   int t_read = -1, t_start = -1, t_to = -1, t_idle = -1;
   logic busy_q = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_bound(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   task automatic fifo_sig();
      i_fifo_empty = (fq.size() == 0);
      i_fifo_data  = (fq.size() == 0) ? '0 : fq[0];
   endtask

   task automatic push(input logic [NB_WORD-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
      fifo_sig();
   endtask

   task automatic flush();
      fq.delete();
      exp_q.delete();
      fifo_sig();
   endtask

   // Runs at the falling edge: transmitter model plus scoreboard.
   task automatic monitor();
      i_tx_done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) i_tx_done = 1'b1;
      end
      if (o_fifo_read) begin n_reads++; t_read = cyc; end
      if (o_timeout) begin n_to++; t_to = cyc; end
      if (!o_busy) burst_run = 0;
      if (busy_q && !o_busy) t_idle = cyc;
      busy_q = o_busy;
      if (o_tx_start) begin
         n_starts++;
         t_start = cyc;
         st_q.push_back(cyc);
         burst_run++;
         chk("burst_len_ok", 32'(burst_run <= BURST_MAX), 1);
         if (exp_q.size() == 0) chk("spurious_start", 1, 0);
         else chk("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
         if (rand_lat) done_lat = $urandom_range(0, 10);
         cd = done_lat;
         // A word completes only if done arrives within the watchdog window.
         if (done_lat >= 1 && done_lat <= TIMEOUT_CYCLES) exp_sent++;
         else exp_to++;
      end
   endtask

   task automatic tick();
      logic rd;
      rd = o_fifo_read;
      @(posedge i_clk);
      #1;
      if (rd && fq.size() > 0) void'(fq.pop_front());
      fifo_sig();
      @(negedge i_clk);
      cyc++;
      monitor();
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!(o_busy == 1'b0 && cd == 0 && (fq.size() == 0 || !i_enable)) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) fail_bound(nm);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_read"}, 32'(o_fifo_read), 0);
      chk({nm, "_start"}, 32'(o_tx_start), 0);
      chk({nm, "_busy"}, 32'(o_busy), 0);
      chk({nm, "_timeout"}, 32'(o_timeout), 0);
      chk({nm, "_data"}, 32'(o_tx_data), 0);
      chk({nm, "_count"}, 32'(o_sent_count), 0);
   endtask

   initial begin
      int c0, b_r, b_t, b_st, k2;
      logic [15:0] b_s;
      int exp_st[6];

      vecs[0] = '{1, 1, 5, 1, 1, 0};
      vecs[1] = '{1, 6, 1, 6, 6, 0};
      vecs[2] = '{1, 2, 0, 2, 0, 2};
      vecs[3] = '{1, 1, 8, 1, 1, 0};   // done on the expiry cycle
      vecs[4] = '{1, 1, 9, 1, 0, 1};   // done one cycle late, ignored
      vecs[5] = '{0, 3, 1, 0, 0, 0};
      vecs[6] = '{1, 9, 3, 9, 9, 0};

      // Asynchronous reset before any clock edge
      #2 i_rst = 1'b0;
      #1 chk_zero("rst_async");
      @(negedge i_clk);
      tick();
      chk_zero("rst_hold");
      i_rst = 1'b1;

      // Single word, done 5 cycles after start
      done_lat = 5;
      c0 = cyc;
      push(8'hA5);
      i_enable = 1'b1;
      wait_idle("single");
      chk("single_read_lat", t_read - c0, 1);
      chk("single_start_lat", t_start - c0, 2);
      chk("single_idle_at", t_idle - c0, 10);
      chk("single_sent", 32'(o_sent_count), 1);
      chk("single_reads", n_reads, 1);

      // Watchdog expiry
      done_lat = 0;
      c0 = cyc;
      push(8'h3C);
      wait_idle("timeout");
      chk("to_start_lat", t_start - c0, 2);
      chk("to_pulse_at", t_to - c0, 11);
      chk("to_idle_at", t_idle - c0, 13);
      chk("to_count", n_to, 1);
      chk("to_sent", 32'(o_sent_count), 1);

      // Done pulsed in IDLE has no effect
      i_tx_done = 1'b1;
      tick();
      tick();
      chk("idle_done_sent", 32'(o_sent_count), 1);
      chk("idle_done_busy", 32'(o_busy), 0);

      // Burst limit with 6 words
      done_lat = 1;
      st_q.delete();
      c0 = cyc;
      for (int i = 1; i <= 6; i++) push(8'(i));
      wait_idle("burst");
      exp_st = '{2, 5, 8, 11, 17, 20};
      chk("burst_nstarts", st_q.size(), 6);
      for (int i = 0; i < 6 && i < st_q.size(); i++)
         chk($sformatf("burst_start%0d_at", i), st_q[i] - c0, exp_st[i]);
      chk("burst_sent", 32'(o_sent_count), 7);
      chk("burst_reads", n_reads, 8);

      // Enable dropped during the second word of a burst
      done_lat = 3;
      b_r = n_reads;
      b_s = o_sent_count;
      b_st = n_starts;
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      k2 = 0;
      while (n_starts < b_st + 2 && k2 < 200) begin tick(); k2++; end
      if (k2 >= 200) fail_bound("endrop_second_start");
      i_enable = 1'b0;
      wait_idle("endrop_idle");
      chk("endrop_reads", n_reads - b_r, 2);
      chk("endrop_sent", 32'(o_sent_count - b_s), 2);
      repeat (50) tick();
      chk("endrop_hold_reads", n_reads - b_r, 2);
      i_enable = 1'b1;
      wait_idle("endrop_drain");
      chk("endrop_drain_reads", n_reads - b_r, 4);

      // Asynchronous reset while BUSY
      done_lat = 0;
      push(8'h5A);
      push(8'h6B);
      push(8'h7C);
      b_st = n_starts;
      k2 = 0;
      while (n_starts == b_st && k2 < 200) begin tick(); k2++; end
      if (k2 >= 200) fail_bound("rst_mid_start");
      tick();
      tick();
      chk("rst_mid_busy_before", 32'(o_busy), 1);
      #2 i_rst = 1'b0;
      #1 chk_zero("rst_mid");
      i_enable = 1'b0;
      cd = 0;
      @(negedge i_clk);
      tick();
      i_rst = 1'b1;
      b_r = n_reads;
      repeat (10) tick();
      chk("rst_release_reads", n_reads - b_r, 0);
      flush();
      i_enable = 1'b1;
      repeat (5) tick();
      chk("rst_empty_reads", n_reads - b_r, 0);
      chk("rst_empty_busy", 32'(o_busy), 0);
      exp_sent = 0;
      exp_to = n_to;

      // Vector table
      foreach (vecs[k]) begin
         b_r = n_reads;
         b_s = o_sent_count;
         b_t = n_to;
         done_lat = vecs[k].lat;
         for (int i = 0; i < vecs[k].nwords; i++) push(8'($urandom));
         i_enable = vecs[k].en;
         if (vecs[k].en) wait_idle($sformatf("vec%0d_idle", k));
         else repeat (50) tick();
         chk($sformatf("vec%0d_reads", k), n_reads - b_r, vecs[k].exp_reads);
         chk($sformatf("vec%0d_sent", k), 32'(o_sent_count - b_s), vecs[k].exp_sent);
         chk($sformatf("vec%0d_timeouts", k), n_to - b_t, vecs[k].exp_to);
         if (!vecs[k].en) flush();
      end

      // Randomized traffic against the scoreboard
      rand_lat = 1;
      i_enable = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int nw;
         nw = $urandom_range(0, 7);
         for (int i = 0; i < nw; i++) push(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 15)) tick();
            i_enable = 1'b0;
            repeat ($urandom_range(0, 20)) tick();
            i_enable = 1'b1;
         end
         wait_idle($sformatf("rand%0d_idle", it));
         chk($sformatf("rand%0d_sent", it), 32'(o_sent_count), 32'(16'(exp_sent)));
         chk($sformatf("rand%0d_timeouts", it), n_to, exp_to);
      end

      chk("final_reads_eq_starts", n_reads, n_starts);
      chk("final_scoreboard_empty", exp_q.size(), 0);
      chk("final_fifo_empty", fq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
